// File: rtl/keccak_pkg.sv
// Shared constants and state encoding for the Keccak front-end blocks.
package keccak_pkg;

  localparam int R_SHA3_256 = 1088;
  localparam int R_SHA3_512 = 576;
  localparam int R_SHAKE128 = 1344;
  localparam int R_SHAKE256 = 1088;

  localparam logic [7:0] DSEP_SHA3  = 8'h06;
  localparam logic [7:0] DSEP_SHAKE = 8'h1F;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } padder_state_t;

endpackage

// File: rtl/keccak_padder_bramd_if.sv
// Word-source and block-sink signals of the padder; slave is the padder side.
interface keccak_padder_bramd_if
  import keccak_pkg::*;
#(
  parameter int R = R_SHA3_512
);
  logic [63:0]  in;
  logic [2:0]   byte_num;
  logic         in_valid;
  logic         is_last;
  logic         buffer_full;
  logic [R-1:0] out;
  logic         out_ready;
  logic         f_ack;

  modport master (
    output in, byte_num, in_valid, is_last, f_ack,
    input  buffer_full, out, out_ready
  );

  modport slave (
    input  in, byte_num, in_valid, is_last, f_ack,
    output buffer_full, out, out_ready
  );
endinterface

// File: rtl/keccak_padder_bramd_last_word.sv
// Pads the final message word: keeps bytes below byte_num, inserts the domain byte, zeros the rest.
module padder_last_word
  import keccak_pkg::*;
#(
  parameter logic [7:0] DSEP = DSEP_SHA3
) (
  input  logic [63:0] in,
  input  logic [2:0]  byte_num,
  output logic [63:0] padded
);

  for (genvar gi = 0; gi < 8; gi++) begin : g_byte
    localparam logic [2:0] BYTE_IDX = 3'(gi);
    assign padded[63-8*gi -: 8] = (BYTE_IDX < byte_num)  ? in[63-8*gi -: 8] :
                                  (BYTE_IDX == byte_num) ? DSEP : 8'h00;
  end

endmodule

// File: rtl/keccak_padder_bramd.sv
// Collects 64-bit message words into one rate block, pads the block holding the last word,
// and holds it for the permutation core until f_ack.
module keccak_padder_bramd
  import keccak_pkg::*;
#(
  parameter int         R    = R_SHA3_512,
  parameter logic [7:0] DSEP = DSEP_SHA3
) (
  input logic                   clk,
  input logic                   reset_n,
  keccak_padder_bramd_if.slave  bus
);

  localparam int W  = R / 64;
  localparam int CW = $clog2(W);

  padder_state_t state_reg;
  logic [CW-1:0] cnt_reg;
  logic          out_ready_reg;
  logic [R-1:0]  out_reg;
  logic [R-1:0]  out_next;
  logic [63:0]   last_word;

  padder_last_word #(.DSEP(DSEP)) u_last_word (
    .in       (bus.in),
    .byte_num (bus.byte_num),
    .padded   (last_word)
  );

  // Each slot decides its own next value; slots past the last word are zeroed so the
  // block is fully padded in the same cycle the last word lands.
  for (genvar gi = 0; gi < W; gi++) begin : g_slot
    localparam logic [CW-1:0] SLOT = CW'(gi);
    logic [63:0] slot_cur;
    logic [63:0] slot_next;

    assign slot_cur = out_reg[R-1-64*gi -: 64];

    always_comb begin
      slot_next = slot_cur;
      if (state_reg == FULL) begin
        if (bus.f_ack) slot_next = '0;
      end else if (bus.in_valid) begin
        if (!bus.is_last) begin
          if (SLOT == cnt_reg) slot_next = bus.in;
        end else begin
          if (SLOT == cnt_reg)     slot_next = last_word;
          else if (SLOT > cnt_reg) slot_next = '0;
          if (gi == W - 1) slot_next[7:0] = slot_next[7:0] | 8'h80;
        end
      end
    end

    assign out_next[R-1-64*gi -: 64] = slot_next;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg     <= FILL;
      cnt_reg       <= '0;
      out_ready_reg <= 1'b0;
      out_reg       <= '0;
    end else begin
      out_reg <= out_next;
      case (state_reg)
        FILL: begin
          if (bus.in_valid) begin
            if (bus.is_last || cnt_reg == CW'(W - 1)) begin
              cnt_reg       <= '0;
              state_reg     <= FULL;
              out_ready_reg <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg + CW'(1);
            end
          end
        end
        FULL: begin
          if (bus.f_ack) begin
            state_reg     <= FILL;
            out_ready_reg <= 1'b0;
          end
        end
        default: state_reg <= FILL;
      endcase
    end
  end

  assign bus.buffer_full = (state_reg != FILL);
  assign bus.out         = out_reg;
  assign bus.out_ready   = out_ready_reg;

endmodule
